// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO with occupancy count, thresholds and flush.
// Define FIFO_SYNC_ERR_EN to build the sticky overflow/underflow flags.
module fifo_sync #(
  parameter int WIDTH     = 32,
  parameter int ADDRWIDTH = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 wpush,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [WIDTH-1:0]     rdata,
  input  logic                 rpop,
  output logic                 rempty,
  output logic                 ralmost_empty,
  output logic [ADDRWIDTH:0]   count,
  input  logic                 flush,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << ADDRWIDTH;

  localparam logic [ADDRWIDTH:0] DEPTH_C = (ADDRWIDTH+1)'(DEPTH);
  localparam logic [ADDRWIDTH:0] AF_C    = (ADDRWIDTH+1)'(AF_THRESH);
  localparam logic [ADDRWIDTH:0] AE_C    = (ADDRWIDTH+1)'(AE_THRESH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDRWIDTH-1:0] wptr;
  logic [ADDRWIDTH-1:0] rptr;
  logic                 w_en;
  logic                 r_en;

  assign w_en = wpush & ~wfull;
  assign r_en = rpop & ~rempty;

  assign wfull         = (count == DEPTH_C);
  assign rempty        = (count == '0);
  assign walmost_full  = (count >= AF_C);
  assign ralmost_empty = (count <= AE_C);

  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (w_en) wptr <= wptr + 1'b1;
      if (r_en) rptr <= rptr + 1'b1;
      unique case ({w_en, r_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; writes are gated so reset/flush discard them.
  always_ff @(posedge clk) begin
    if (rstn && !flush && w_en) mem[wptr] <= wdata;
  end

`ifdef FIFO_SYNC_ERR_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wpush && wfull)  overflow  <= 1'b1;
      if (rpop  && rempty) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Scoreboard bench for fifo_sync: stimulus queues expected words,
// a negedge monitor checks rdata on every accepted pop.
module tb_fifo_sync;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] wdata = '0;
  logic        wpush = 1'b0;
  logic        wfull;
  logic        walmost_full;
  logic [31:0] rdata;
  logic        rpop = 1'b0;
  logic        rempty;
  logic        ralmost_empty;
  logic [4:0]  count;
  logic        flush = 1'b0;
  logic        overflow;
  logic        underflow;

  fifo_sync #(
    .WIDTH(32), .ADDRWIDTH(4), .AF_THRESH(12), .AE_THRESH(4)
  ) dut (
    .clk(clk), .rstn(rstn), .wdata(wdata), .wpush(wpush),
    .wfull(wfull), .walmost_full(walmost_full), .rdata(rdata),
    .rpop(rpop), .rempty(rempty), .ralmost_empty(ralmost_empty),
    .count(count), .flush(flush), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          mcount = 0;
  bit          movf = 0;
  bit          munf = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: any pop accepted at the coming edge consumes the head word.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rstn && !flush && rpop && !rempty) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rdata: got %0h expected none (queue empty)", rdata);
      end else begin
        e = exp_q.pop_front();
        if (rdata !== e) begin
          n_fail++;
          $display("FAIL rdata: got %0h expected %0h", rdata, e);
        end
      end
    end
  end

  task automatic check_state();
    chk("count", 32'(count), 32'(mcount));
    chk("wfull", 32'(wfull), 32'(mcount == 16));
    chk("rempty", 32'(rempty), 32'(mcount == 0));
    chk("walmost_full", 32'(walmost_full), 32'(mcount >= 12));
    chk("ralmost_empty", 32'(ralmost_empty), 32'(mcount <= 4));
`ifdef FIFO_SYNC_ERR_EN
    chk("overflow", 32'(overflow), 32'(movf));
    chk("underflow", 32'(underflow), 32'(munf));
`else
    chk("overflow", 32'(overflow), 32'd0);
    chk("underflow", 32'(underflow), 32'd0);
`endif
  endtask

  task automatic step(input bit p, input bit q, input logic [31:0] d,
                      input bit f, input bit rn);
    bit aw;
    bit ar;
    wpush = p;
    rpop  = q;
    wdata = d;
    flush = f;
    rstn  = rn;
    aw = p && (mcount < 16) && !f && rn;
    ar = q && (mcount > 0) && !f && rn;
    if (aw) exp_q.push_back(d);
    @(posedge clk);
    if (!rn || f) begin
      mcount = 0;
      movf = 0;
      munf = 0;
      exp_q.delete();
    end else begin
      if (p && mcount == 16) movf = 1;
      if (q && mcount == 0) munf = 1;
      mcount = mcount + int'(aw) - int'(ar);
    end
    #1;
    check_state();
  endtask

  task automatic push(input logic [31:0] d);
    step(1, 0, d, 0, 1);
  endtask

  task automatic pop();
    step(0, 1, 32'd0, 0, 1);
  endtask

  task automatic idle();
    step(0, 0, 32'd0, 0, 1);
  endtask

  initial begin
    // Reset then idle
    step(0, 0, 32'd0, 0, 0);
    step(0, 0, 32'd0, 0, 0);
    idle();

    // Fill 0x00..0x0F, then drain in order
    for (int i = 0; i < 16; i++) push(32'(i));
    for (int i = 0; i < 16; i++) pop();
    idle();

    // Push+pop while full: push rejected
    for (int i = 0; i < 16; i++) push(32'h100 + 32'(i));
    step(1, 1, 32'hEE, 0, 1);
    chk("full_pushpop_count", 32'(count), 32'd15);
    for (int i = 0; i < 15; i++) pop();

    // Push+pop while empty: only push accepted, no bypass
    step(1, 1, 32'hA5, 0, 1);
    chk("empty_pushpop_rdata", rdata, 32'hA5);
    pop();

    // Wrap-around with steady occupancy of 3
    for (int i = 0; i < 3; i++) push(32'h200 + 32'(i));
    for (int i = 3; i < 20; i++) step(1, 1, 32'h200 + 32'(i), 0, 1);
    for (int i = 0; i < 3; i++) pop();

    // Flush with concurrent push
    for (int i = 0; i < 7; i++) push(32'h300 + 32'(i));
    step(1, 0, 32'h3FF, 1, 1);
    idle();

    // Reset mid-stream with concurrent push and pop
    for (int i = 0; i < 5; i++) push(32'h400 + 32'(i));
    step(1, 1, 32'h4FF, 0, 0);
    idle();

    // Still functional after reset
    push(32'h5A5A);
    pop();
    idle();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_sync.md
# fifo_sync

Single-clock, parametrised FIFO for buffering within one clock domain, sharing the `sram_lib`-style storage model with the dual-clock FIFO family. It adds what the dual-clock variant lacks: an exact occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and optional sticky overflow/underflow error flags. It sits between a producer and a consumer that share `clk`, wherever cross-domain pointer synchronisation is unnecessary overhead.

## Interface
Parameters:
- `WIDTH`, 32, data word width in bits.
- `ADDRWIDTH`, 4, address width; DEPTH = 2^ADDRWIDTH entries.
- `AF_THRESH`, 12, `walmost_full` asserts when count >= AF_THRESH; legal range 1..DEPTH.
- `AE_THRESH`, 4, `ralmost_empty` asserts when count <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- `clk` input 1: the single clock; all logic is on its rising edge.
- `rstn` input 1: reset, synchronous and active-low.
- `wdata` input WIDTH: write data.
- `wpush` input 1: write request.
- `wfull` output 1: FIFO holds DEPTH words.
- `walmost_full` output 1: count >= AF_THRESH.
- `rdata` output WIDTH: head-of-FIFO word; valid while `rempty`=0.
- `rpop` input 1: read request; consumes the word on `rdata`.
- `rempty` output 1: FIFO holds 0 words.
- `ralmost_empty` output 1: count <= AE_THRESH.
- `count` output ADDRWIDTH+1: current occupancy, 0..DEPTH.
- `flush` input 1: synchronous clear of contents.
- `overflow` output 1: sticky, push attempted while full (see Configuration).
- `underflow` output 1: sticky, pop attempted while empty (see Configuration).

## Operation
- State: write pointer `wptr` and read pointer `rptr` (ADDRWIDTH bits each, natural wrap DEPTH-1 -> 0), `count` register (ADDRWIDTH+1 bits), and storage array of DEPTH x WIDTH.
- Accepted push: `w_en = wpush & ~wfull`. Writes `wdata` to mem[wptr] and increments `wptr`.
- Accepted pop: `r_en = rpop & ~rempty`. Increments `rptr`.
- Count update: +1 on push-only, -1 on pop-only, and unchanged when both or neither are accepted.
- Flags are decoded from the registered `count`:
  - `wfull` = (count == DEPTH).
  - `rempty` = (count == 0).
  - `walmost_full` = (count >= AF_THRESH).
  - `ralmost_empty` = (count <= AE_THRESH).
- `rdata` = mem[rptr], an asynchronous read (show-ahead). The value while empty is don't-care. Storage is never reset.
- Simultaneous push and pop:
  - When not full and not empty, both are accepted and count holds.
  - When full, only the pop is accepted; the push is rejected and count becomes DEPTH-1.
  - When empty, only the push is accepted. There is no bypass: `rempty` stays 1 that cycle and the word is visible on the next cycle.
- `flush`: has priority over push and pop. `wptr`, `rptr` and `count` go to 0; pushes and pops in that cycle are discarded.
- Reset (`rstn`=0 at a clock edge), including mid-operation: pointers=0 and count=0, so `wfull`=0, `rempty`=1, `walmost_full`=(AF_THRESH==0 ? 1 : 0)=0, `ralmost_empty`=1, `overflow`=0, `underflow`=0. Reset overrides `flush`, `wpush` and `rpop`.

## Timing
- All state updates on the rising edge of `clk`. Outputs are functions of registers only, so there is no combinational path from `wpush` or `rpop` to any output.
- Write-to-read latency: a word pushed at edge N is on `rdata` with `rempty`=0 after edge N (usable at edge N+1), provided it is the head.
- Flags and `count` reflect edge N's operations immediately after edge N.
- Reject behaviour: a push while `wfull`=1 leaves state unchanged; a pop while `rempty`=1 leaves state unchanged.

## Configuration
- Macro: `FIFO_SYNC_ERR_EN`.
- Defined:
  - `overflow` sets on any edge with `wpush & wfull`.
  - `underflow` sets on any edge with `rpop & rempty`.
  - Both are sticky and cleared only by reset or `flush`.
  - Setting takes priority over clearing in the same cycle only when `flush`=0.
- Undefined: `overflow` and `underflow` are tied to 0 and no flag registers exist. The ports remain so integration is unaffected.

## Test plan
All scenarios use DEPTH=16, AF_THRESH=12, AE_THRESH=4.
- Reset then idle -> `rempty`=1, `wfull`=0, `count`=0, `ralmost_empty`=1, `walmost_full`=0, `overflow`=`underflow`=0.
- Push 0x00..0x0F on 16 consecutive edges, then pop 16 words:
  - `count` steps 1..16; `walmost_full` rises after the 12th push; `wfull` rises after the 16th.
  - `rdata` reads back 0x00..0x0F in order; `rempty`=1 after the 16th pop.
- Fill to 16, then push+pop together for 1 edge -> pop accepted, push rejected, `count`=15. With `FIFO_SYNC_ERR_EN` defined, `overflow`=1.
- From empty, push 0xA5 with `rpop`=1 on the same edge -> `count`=1, `rdata`=0xA5 next cycle. With `FIFO_SYNC_ERR_EN` defined, `underflow`=1.
- Wrap-around: push 20 and pop 20 interleaved with a steady occupancy of 3 -> data order preserved across the pointer wrap, and `count` never deviates from 3 during steady state.
- Push 7 words, then assert `flush` with `wpush`=1 on the same edge -> `count`=0, `rempty`=1, error flags=0. Asserting `rstn`=0 mid-stream gives the same result.
